// File: rtl/frac_reduce_if.sv
// Handshake bus for frac_reduce.
// Upstream side: in_valid/in_ready with num, den, gcd_in operands.
// Downstream side: out_valid/out_ready with num_red, den_red, div_err
// (and lcm_out when FRAC_REDUCE_LCM_EN is defined).
// master: the block's environment (drives operands, consumes results).
// slave:  the frac_reduce block itself.
interface frac_reduce_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  num;
  logic [7:0]  den;
  logic [7:0]  gcd_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  num_red;
  logic [7:0]  den_red;
  logic        div_err;
`ifdef FRAC_REDUCE_LCM_EN
  logic [15:0] lcm_out;

  modport master (
    output in_valid, num, den, gcd_in, out_ready,
    input  in_ready, out_valid, num_red, den_red, div_err, lcm_out
  );
  modport slave (
    input  in_valid, num, den, gcd_in, out_ready,
    output in_ready, out_valid, num_red, den_red, div_err, lcm_out
  );
`else
  modport master (
    output in_valid, num, den, gcd_in, out_ready,
    input  in_ready, out_valid, num_red, den_red, div_err
  );
  modport slave (
    input  in_valid, num, den, gcd_in, out_ready,
    output in_ready, out_valid, num_red, den_red, div_err
  );
`endif
endinterface

// File: rtl/frac_reduce.sv
// frac_reduce: divides a numerator/denominator pair by a supplied gcd using
// a serial restoring divider (8 cycles per operand, MSB first).
// Optional feature macro: FRAC_REDUCE_LCM_EN adds a MUL state computing
// lcm_out = num_red * den with an 8-cycle shift-add multiplier.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - frac_reduce_if.slave (operand and result handshakes)
module frac_reduce (
  input logic        clk,
  input logic        rst_n,
  frac_reduce_if.slave bus
);

`ifdef FRAC_REDUCE_LCM_EN
  typedef enum logic [2:0] {StIdle, StDivNum, StDivDen, StDone, StMul} state_e;
`else
  typedef enum logic [1:0] {StIdle, StDivNum, StDivDen, StDone} state_e;
`endif

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [8:0]  rem_q, rem_d;     // partial remainder; 9 bits holds the shifted trial
  logic [7:0]  dq_q, dq_d;       // dividend shifts out the top, quotient shifts in below
  logic [7:0]  gcd_q, gcd_d;
  logic [7:0]  den_op_q, den_op_d;
  logic [7:0]  numq_q, numq_d;
  logic        err_q, err_d;
  logic [7:0]  num_red_q, num_red_d;
  logic [7:0]  den_red_q, den_red_d;
  logic        div_err_q, div_err_d;
`ifdef FRAC_REDUCE_LCM_EN
  logic [7:0]  denq_q, denq_d;
  logic [15:0] mcand_q, mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] acc_next;
  logic [15:0] lcm_q, lcm_d;
`endif

  logic        accept;
  logic [8:0]  trial;
  logic        qbit;
  logic [8:0]  rem_next;
  logic [7:0]  dq_next;

  assign accept = bus.in_valid && (state_q == StIdle);

  // One restoring-division step on the current working registers.
  always_comb begin
    trial    = {rem_q[7:0], dq_q[7]};
    qbit     = (trial >= {1'b0, gcd_q});
    rem_next = qbit ? (trial - {1'b0, gcd_q}) : trial;
    dq_next  = {dq_q[6:0], qbit};
  end

`ifdef FRAC_REDUCE_LCM_EN
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dq_d      = dq_q;
    gcd_d     = gcd_q;
    den_op_d  = den_op_q;
    numq_d    = numq_q;
    err_d     = err_q;
    num_red_d = num_red_q;
    den_red_d = den_red_q;
    div_err_d = div_err_q;
`ifdef FRAC_REDUCE_LCM_EN
    denq_d    = denq_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    lcm_d     = lcm_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          gcd_d    = bus.gcd_in;
          den_op_d = bus.den;
          if (bus.gcd_in == 8'd0) begin
            // Division by zero: pass operands through flagged as an error.
            num_red_d = bus.num;
            den_red_d = bus.den;
            div_err_d = 1'b1;
`ifdef FRAC_REDUCE_LCM_EN
            lcm_d     = 16'h0000;
`endif
            state_d   = StDone;
          end else begin
            dq_d    = bus.num;
            rem_d   = 9'd0;
            cnt_d   = 3'd0;
            state_d = StDivNum;
          end
        end
      end
      StDivNum: begin
        rem_d = rem_next;
        dq_d  = dq_next;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          numq_d  = dq_next;
          err_d   = (rem_next != 9'd0);
          dq_d    = den_op_q;
          rem_d   = 9'd0;
          state_d = StDivDen;
        end
      end
      StDivDen: begin
        rem_d = rem_next;
        dq_d  = dq_next;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
`ifdef FRAC_REDUCE_LCM_EN
          denq_d   = dq_next;
          err_d    = err_q | (rem_next != 9'd0);
          mcand_d  = {8'h00, den_op_q};
          mplier_d = numq_q;
          acc_d    = 16'h0000;
          state_d  = StMul;
`else
          num_red_d = numq_q;
          den_red_d = dq_next;
          div_err_d = err_q | (rem_next != 9'd0);
          state_d   = StDone;
`endif
        end
      end
`ifdef FRAC_REDUCE_LCM_EN
      StMul: begin
        acc_d    = acc_next;
        mcand_d  = {mcand_q[14:0], 1'b0};
        mplier_d = {1'b0, mplier_q[7:1]};
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          num_red_d = numq_q;
          den_red_d = denq_q;
          div_err_d = err_q;
          lcm_d     = err_q ? 16'h0000 : acc_next;
          state_d   = StDone;
        end
      end
`endif
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      rem_q     <= 9'd0;
      dq_q      <= 8'd0;
      gcd_q     <= 8'd0;
      den_op_q  <= 8'd0;
      numq_q    <= 8'd0;
      err_q     <= 1'b0;
      num_red_q <= 8'd0;
      den_red_q <= 8'd0;
      div_err_q <= 1'b0;
`ifdef FRAC_REDUCE_LCM_EN
      denq_q    <= 8'd0;
      mcand_q   <= 16'h0000;
      mplier_q  <= 8'd0;
      acc_q     <= 16'h0000;
      lcm_q     <= 16'h0000;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dq_q      <= dq_d;
      gcd_q     <= gcd_d;
      den_op_q  <= den_op_d;
      numq_q    <= numq_d;
      err_q     <= err_d;
      num_red_q <= num_red_d;
      den_red_q <= den_red_d;
      div_err_q <= div_err_d;
`ifdef FRAC_REDUCE_LCM_EN
      denq_q    <= denq_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      lcm_q     <= lcm_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.num_red   = num_red_q;
  assign bus.den_red   = den_red_q;
  assign bus.div_err   = div_err_q;
`ifdef FRAC_REDUCE_LCM_EN
  assign bus.lcm_out   = lcm_q;
`endif

endmodule

// File: tb/tb_frac_reduce.sv
// Self-checking bench for frac_reduce: directed vectors, randomized operands
// against an arithmetic reference model, backpressure and mid-operation reset.
module tb_frac_reduce;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  frac_reduce_if bus ();

  frac_reduce dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

`ifdef FRAC_REDUCE_LCM_EN
  localparam int DivLat = 25;
`else
  localparam int DivLat = 17;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer one triple, wait for out_valid; lat counts edges with accept edge as 1.
  task automatic start_op(input logic [7:0] n, input logic [7:0] d, input logic [7:0] g,
                          output int lat);
    @(negedge clk);
    check("in_ready_before", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.num      = n;
    bus.den      = d;
    bus.gcd_in   = g;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input logic [7:0] n, input logic [7:0] d, input logic [7:0] g,
                              input int lat);
    logic [7:0]  e_num, e_den;
    logic        e_err;
    int          e_lat;
    if (g == 8'd0) begin
      e_num = n;
      e_den = d;
      e_err = 1'b1;
      e_lat = 1;
    end else begin
      e_num = n / g;
      e_den = d / g;
      e_err = ((n % g) != 0) || ((d % g) != 0);
      e_lat = DivLat;
    end
    check("out_valid", 32'(bus.out_valid), 32'd1);
    check("latency", 32'(lat), 32'(e_lat));
    check("num_red", 32'(bus.num_red), 32'(e_num));
    check("den_red", 32'(bus.den_red), 32'(e_den));
    check("div_err", 32'(bus.div_err), 32'(e_err));
`ifdef FRAC_REDUCE_LCM_EN
    check("lcm_out", 32'(bus.lcm_out), e_err ? 32'd0 : (32'(e_num) * 32'(d)));
`endif
  endtask

  task automatic run_op(input logic [7:0] n, input logic [7:0] d, input logic [7:0] g);
    int lat;
    start_op(n, d, g, lat);
    check_result(n, d, g, lat);
    // out_ready is high, so this edge completes the result handshake.
    @(posedge clk);
    #1;
    check("out_valid_drop", 32'(bus.out_valid), 32'd0);
    check("in_ready_after", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic [7:0] rn, rd, rg;
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.num      = 8'd0;
    bus.den      = 8'd0;
    bus.gcd_in   = 8'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_num_red", 32'(bus.num_red), 32'd0);
    check("rst_den_red", 32'(bus.den_red), 32'd0);
    check("rst_div_err", 32'(bus.div_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    run_op(8'd12, 8'd18, 8'd6);
    run_op(8'd7, 8'd9, 8'd0);
    run_op(8'd255, 8'd255, 8'd255);
    run_op(8'd0, 8'd5, 8'd5);
    run_op(8'd10, 8'd15, 8'd4);
    run_op(8'd255, 8'd255, 8'd1);
    run_op(8'd200, 8'd3, 8'd1);

    // Randomized: mix of exact multiples, arbitrary divisors and zero gcd.
    for (int i = 0; i < 40; i++) begin
      case (i % 4)
        0: begin
          rg = 8'($urandom_range(1, 20));
          rn = 8'(rg * $urandom_range(0, 255 / rg));
          rd = 8'(rg * $urandom_range(0, 255 / rg));
        end
        1: begin
          rg = 8'd0;
          rn = 8'($urandom_range(0, 255));
          rd = 8'($urandom_range(0, 255));
        end
        default: begin
          rg = 8'($urandom_range(1, 255));
          rn = 8'($urandom_range(0, 255));
          rd = 8'($urandom_range(0, 255));
        end
      endcase
      run_op(rn, rd, rg);
    end

    // Backpressure: result must hold and new offers must be ignored.
    bus.out_ready = 1'b0;
    start_op(8'd100, 8'd60, 8'd20, lat);
    check_result(8'd100, 8'd60, 8'd20, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.num      = 8'(i + 1);
      bus.den      = 8'(i + 2);
      bus.gcd_in   = 8'd1;
      @(posedge clk);
      #1;
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_num", 32'(bus.num_red), 32'd5);
      check("stall_den", 32'(bus.den_red), 32'd3);
      check("stall_err", 32'(bus.div_err), 32'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_valid", 32'(bus.out_valid), 32'd0);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    check("retain_num", 32'(bus.num_red), 32'd5);
    check("retain_den", 32'(bus.den_red), 32'd3);
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_accept", 32'(bus.out_valid), 32'd0);

    // Reset during the fourth DIV_NUM cycle.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.num      = 8'd12;
    bus.den      = 8'd18;
    bus.gcd_in   = 8'd6;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_num", 32'(bus.num_red), 32'd0);
    check("mid_rst_den", 32'(bus.den_red), 32'd0);
    check("mid_rst_err", 32'(bus.div_err), 32'd0);
`ifdef FRAC_REDUCE_LCM_EN
    check("mid_rst_lcm", 32'(bus.lcm_out), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd12, 8'd18, 8'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frac_reduce.md
FRAC_REDUCE -- requirements
Module: frac_reduce

Interface
REQ-001: clk  input  1  single clock; all state changes on rising edge.
REQ-002: rst_n  input  1  asynchronous active-low reset.
REQ-003: in_valid  input  1  operand triple offered.
REQ-004: in_ready  output  1  block accepts operands this cycle.
REQ-005: num  input  8  unsigned numerator, sampled on accept.
REQ-006: den  input  8  unsigned denominator, sampled on accept.
REQ-007: gcd_in  input  8  gcd of num/den produced by the upstream gcd stage, sampled on accept.
REQ-008: out_valid  output  1  result held and valid.
REQ-009: out_ready  input  1  consumer takes result.
REQ-010: num_red  output  8  floor(num/gcd_in).
REQ-011: den_red  output  8  floor(den/gcd_in).
REQ-012: div_err  output  1  gcd_in zero, or nonzero remainder on either division.
REQ-013: lcm_out  output  16  least common multiple; present only with FRAC_REDUCE_LCM_EN.

Function
REQ-014: FSM states SHALL be IDLE, DIV_NUM, DIV_DEN, DONE, plus MUL when FRAC_REDUCE_LCM_EN is defined.
REQ-015: in_ready SHALL be 1 only in IDLE; accept = in_valid && in_ready; accept registers num, den, gcd_in.
REQ-016: On accept with gcd_in != 0: IDLE -> DIV_NUM.
REQ-017: On accept with gcd_in == 0: IDLE -> DONE; num_red=num, den_red=den, div_err=1; out_valid on the next cycle.
REQ-018: DIV_NUM SHALL run an 8-step restoring shift-subtract division, one quotient bit per cycle, MSB first, exactly 8 cycles; then -> DIV_DEN.
REQ-019: DIV_DEN SHALL perform the same 8-cycle division on den; then -> DONE (or -> MUL when LCM enabled).
REQ-020: Remainder datapath SHALL be 9 bits so that 255/1 and 255/255 are exact; quotients are 8 bits.
REQ-021: Latency without LCM: out_valid rises 17 rising edges after the accept edge; constant for every gcd_in != 0, including gcd_in == 1.
REQ-022: div_err SHALL be the OR of the two final remainders being nonzero; quotients are still reported.
REQ-023: In DONE, out_valid=1 and num_red, den_red, div_err, lcm_out SHALL hold stable until out_valid && out_ready; then -> IDLE, out_valid=0 next cycle.
REQ-024: No new accept while out_valid=1; in_valid is ignored in all states except IDLE.
REQ-025: Outputs SHALL retain the last result after return to IDLE until the next result overwrites them.

Reset
REQ-026: rst_n low SHALL immediately force IDLE, in_ready=1 once released, out_valid=0, num_red=0, den_red=0, div_err=0, lcm_out=0.
REQ-027: Reset asserted mid-division SHALL discard the operation; no partial result is ever presented.
REQ-028: Release is synchronous-deasserted externally; block is ready to accept on the first edge after release.

Configuration
REQ-029: Macro FRAC_REDUCE_LCM_EN.
REQ-030: Defined: lcm_out port exists; after DIV_DEN, state MUL computes num_red*den (8x8 shift-add, 8 cycles); latency becomes 25 edges; lcm_out = 0 when div_err=1.
REQ-031: Undefined: no lcm_out port, no MUL state, no multiplier logic; latency 17.

Verification
REQ-032: num=12, den=18, gcd_in=6, out_ready=1 -> num_red=2, den_red=3, div_err=0, out_valid 17 edges after accept (25 with LCM, lcm_out=36).
REQ-033: num=7, den=9, gcd_in=0 -> num_red=7, den_red=9, div_err=1, out_valid 1 edge after accept.
REQ-034: num=255, den=255, gcd_in=255 -> 1/1, div_err=0; num=0, den=5, gcd_in=5 -> 0/1.
REQ-035: num=10, den=15, gcd_in=4 -> num_red=2, den_red=3, div_err=1.
REQ-036: out_ready held 0 for 10 cycles after out_valid -> outputs stable, in_ready=0, new in_valid ignored; release -> IDLE next cycle.
REQ-037: rst_n pulsed low during DIV_NUM cycle 4 -> out_valid=0, all outputs 0 asynchronously; next triple 12/18/6 completes correctly.
